mult_seq_ctrl: RTL and testbench

//  Sequencer for an iterative 32x32 -> 64-bit shift-add multiplier (MULT/MULTU).
//  The multiply itself is built from an external 32-bit adder:
//   - this block drives the adder operands (AddA/AddB);
//   - it reads back the adder's 32-bit sum (AddSum).
//  It sits in the EX stage beside the ALU and owns the HI/LO result registers.
//  The pipeline holds the stall while Busy is high.

---
 rtl/mult_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Sequencer for an iterative 32x32 -> 64-bit shift-add multiplier
//   (MULT/MULTU). One partial-product bit is retired per cycle using an
//   external 32-bit adder. The block owns the HI/LO result registers.
//
// Ports
//   Clk     in   1   clock, rising edge
//   Rst     in   1   asynchronous reset, active-low
//   Start   in   1   request, sampled in IDLE only
//   Signed  in   1   1 = MULT (two's complement), 0 = MULTU
//   A       in   32  multiplicand, captured on the Start edge
//   B       in   32  multiplier, captured on the Start edge
//   Abort   in   1   flush; cancels the operation in flight
//   AddA    out  32  adder operand A (zero outside ITER)
//   AddB    out  32  adder operand B (zero outside ITER)
//   AddSum  in   32  combinational AddA+AddB from the external adder
//   Busy    out  1   high in LOAD/ITER/FIX/DONE
//   Done    out  1   one-cycle pulse, Hi/Lo valid from this cycle on
//   Hi      out  32  product[63:32]
//   Lo      out  32  product[31:0]
// ---------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter bit SIGNED_EN  = 1'b1,
  parameter bit EARLY_ZERO = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Abort,
  output logic [31:0] AddA,
  output logic [31:0] AddB,
  input  logic [31:0] AddSum,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Magnitude of a 32-bit operand; 0x80000000 maps onto itself, which is
  // the correct magnitude once read as unsigned.
  function automatic logic [31:0] abs_mag(input logic [31:0] x, input logic sgn);
    abs_mag = (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // 64-bit two's complement negation.
  function automatic logic [63:0] neg64(input logic [63:0] x);
    neg64 = 64'd0 - x;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] a_r, a_nxt_s;
  logic [31:0] b_r, b_nxt_s;
  logic        sgn_r, sgn_nxt_s;
  logic [31:0] mcand_r, mcand_nxt_s;
  logic [31:0] p_hi_r, p_hi_nxt_s;
  logic [31:0] p_lo_r, p_lo_nxt_s;
  logic        neg_r, neg_nxt_s;
  logic [4:0]  cnt_r, cnt_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic        busy_r, done_r;
  logic [31:0] add_a_r, add_b_r;
  logic        carry_s;
  logic [63:0] fix_s;

  assign AddA = add_a_r;
  assign AddB = add_b_r;
  assign Busy = busy_r;
  assign Done = done_r;
  assign Hi   = hi_r;
  assign Lo   = lo_r;

  // Carry out of the external 32-bit add, recovered from the operand and sum MSBs.
  always_comb begin
    carry_s = (AddA[31] & AddB[31]) | ((AddA[31] | AddB[31]) & ~AddSum[31]);
    fix_s   = neg_r ? neg64({p_hi_r, p_lo_r}) : {p_hi_r, p_lo_r};
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    sgn_nxt_s   = sgn_r;
    mcand_nxt_s = mcand_r;
    p_hi_nxt_s  = p_hi_r;
    p_lo_nxt_s  = p_lo_r;
    neg_nxt_s   = neg_r;
    cnt_nxt_s   = cnt_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    case (state_r)
      ST_IDLE: begin
        // Abort outranks a simultaneous Start.
        if (Start && !Abort) begin
          a_nxt_s     = A;
          b_nxt_s     = B;
          sgn_nxt_s   = Signed & SIGNED_EN;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (Abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          mcand_nxt_s = abs_mag(a_r, sgn_r);
          p_lo_nxt_s  = abs_mag(b_r, sgn_r);
          p_hi_nxt_s  = 32'd0;
          neg_nxt_s   = sgn_r & (a_r[31] ^ b_r[31]);
          cnt_nxt_s   = 5'd0;
          if (EARLY_ZERO && ((a_r == 32'd0) || (b_r == 32'd0))) begin
            p_lo_nxt_s  = 32'd0;
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        if (Abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          {p_hi_nxt_s, p_lo_nxt_s} = {carry_s, AddSum, p_lo_r[31:1]};
          cnt_nxt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_ITER;
          end
        end
      end
      ST_FIX: begin
        if (Abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          {hi_nxt_s, lo_nxt_s} = fix_s;
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: begin
        // Results are already committed; Abort is irrelevant here.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sgn_r   <= 1'b0;
      mcand_r <= 32'd0;
      p_hi_r  <= 32'd0;
      p_lo_r  <= 32'd0;
      neg_r   <= 1'b0;
      cnt_r   <= 5'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      sgn_r   <= sgn_nxt_s;
      mcand_r <= mcand_nxt_s;
      p_hi_r  <= p_hi_nxt_s;
      p_lo_r  <= p_lo_nxt_s;
      neg_r   <= neg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
    end
  end

  // Registered status and adder operands, decoded from the upcoming state so
  // that in ITER AddA/AddB already reflect the current partial product.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      add_a_r <= 32'd0;
      add_b_r <= 32'd0;
    end else begin
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      add_a_r <= (state_nxt_s == ST_ITER) ? p_hi_nxt_s : 32'd0;
      add_b_r <= ((state_nxt_s == ST_ITER) && p_lo_nxt_s[0]) ? mcand_nxt_s : 32'd0;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_ctrl
//   Drives three instances side by side from one stimulus stream:
//   dut 0 default parameters, dut 1 SIGNED_EN=0, dut 2 EARLY_ZERO=1.
//   Each has its own behavioural adder. Expected products come from plain
//   64-bit arithmetic; expected latency from the documented edge counts.
// ---------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;

  logic [31:0] add_a   [3];
  logic [31:0] add_b   [3];
  logic [31:0] add_sum [3];
  logic        busy    [3];
  logic        done    [3];
  logic [31:0] hi      [3];
  logic [31:0] lo      [3];

  int checks   = 0;
  int failures = 0;

  logic [63:0] prev_res [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign add_sum[g] = add_a[g] + add_b[g];
    mult_seq_ctrl #(
      .SIGNED_EN  (g != 1),
      .EARLY_ZERO (g == 2)
    ) u_dut (
      .Clk    (clk),
      .Rst    (rst_n),
      .Start  (start),
      .Signed (sgn),
      .A      (a),
      .B      (b),
      .Abort  (abort),
      .AddA   (add_a[g]),
      .AddB   (add_b[g]),
      .AddSum (add_sum[g]),
      .Busy   (busy[g]),
      .Done   (done[g]),
      .Hi     (hi[g]),
      .Lo     (lo[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something unexpected blocks the sequence.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end else begin
      return {32'd0, x} * {32'd0, y};
    end
  endfunction

  // One operation over a fixed 36-cycle window. Caller is just past a
  // negedge; on return the bench is just past a negedge with Start low, so
  // consecutive calls issue back-to-back (Start in the cycle after Done).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit ts,
                        input int abort_at, input int restart_at);
    logic [63:0] exp_res [3];
    int          exp_lat [3];
    int          done_cnt[3];
    int          first   [3];
    logic [63:0] got_res [3];
    bit          zero_ok;
    bit          ez;
    ez = (ta == 32'd0) || (tb_v == 32'd0);
    exp_res[0] = model(ta, tb_v, ts);
    exp_res[1] = model(ta, tb_v, 1'b0);
    exp_res[2] = exp_res[0];
    exp_lat[0] = 35;
    exp_lat[1] = 35;
    exp_lat[2] = ez ? 3 : 35;
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      first[i]    = 0;
      got_res[i]  = 64'd0;
    end
    zero_ok = 1'b1;
    start = 1'b1; a = ta; b = tb_v; sgn = ts; abort = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          if (first[i] == 0) begin
            first[i]   = k;
            got_res[i] = {hi[i], lo[i]};
          end
        end
      end
      if (ez && ((add_a[2] !== 32'd0) || (add_b[2] !== 32'd0))) zero_ok = 1'b0;
      if (k == 1) begin
        for (int i = 0; i < 3; i++) check_val($sformatf("d%0d_busy_rise", i), {63'd0, busy[i]}, 64'd1);
      end
      if (k == 20) begin
        for (int i = 0; i < 3; i++)
          if (exp_lat[i] > 20) check_val($sformatf("d%0d_hilo_hold", i), {hi[i], lo[i]}, prev_res[i]);
      end
      if (abort_at > 0 && k == abort_at + 1) begin
        for (int i = 0; i < 3; i++) check_val($sformatf("d%0d_abort_idle", i), {63'd0, busy[i]}, 64'd0);
      end
      if (k == 36) begin
        for (int i = 0; i < 3; i++) check_val($sformatf("d%0d_busy_end", i), {63'd0, busy[i]}, 64'd0);
      end
      // Drive for the next edge.
      start = (restart_at > 0) && (k == restart_at);
      if (start) begin
        a = ~ta; b = ~tb_v; sgn = ~ts;
      end
      abort = (abort_at > 0) && (k == abort_at);
    end
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (abort_at > 0) begin
        check_val($sformatf("d%0d_abort_nodone", i), 64'(done_cnt[i]), 64'd0);
        check_val($sformatf("d%0d_abort_hilo", i), {hi[i], lo[i]}, prev_res[i]);
      end else begin
        check_val($sformatf("d%0d_done_cnt", i), 64'(done_cnt[i]), 64'd1);
        check_val($sformatf("d%0d_latency", i), 64'(first[i]), 64'(exp_lat[i]));
        check_val($sformatf("d%0d_product", i), got_res[i], exp_res[i]);
        check_val($sformatf("d%0d_hilo_after", i), {hi[i], lo[i]}, exp_res[i]);
        prev_res[i] = exp_res[i];
      end
    end
    if (ez) check_val("d2_adder_idle", {63'd0, zero_ok}, 64'd1);
  endtask

  logic [31:0] corner [6];

  initial begin
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h0000_0001;
    corner[5] = 32'hFFFF_FFFE;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = 32'd0; b = 32'd0; abort = 1'b0;
    for (int i = 0; i < 3; i++) prev_res[i] = 64'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("d%0d_rst_hilo", i), {hi[i], lo[i]}, 64'd0);
      check_val($sformatf("d%0d_rst_stat", i), {62'd0, busy[i], done[i]}, 64'd0);
      check_val($sformatf("d%0d_rst_add", i), {add_a[i], add_b[i]}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 1'b0, 0, 0);
    run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 10);   // Start while busy ignored
    run_op(32'd7, 32'hFFFF_FFF7, 1'b1, 0, 0);              // back-to-back issue
    run_op(32'd0, 32'h0000_1234, 1'b0, 0, 0);              // early-zero path on dut 2
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 9, 0);      // Abort at ITER cycle 7

    // Abort together with Start in IDLE: nothing starts.
    start = 1'b1; abort = 1'b1; a = 32'd5; b = 32'd5; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) check_val($sformatf("d%0d_abort_start", i), {63'd0, busy[i]}, 64'd0);

    for (int n = 0; n < 10; n++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0, 0);
    end

    // Reset dropped mid-ITER clears outputs without waiting for a clock edge.
    start = 1'b1; a = 32'hCAFE_0001; b = 32'h0BAD_F00D; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("d%0d_midrst_hilo", i), {hi[i], lo[i]}, 64'd0);
      check_val($sformatf("d%0d_midrst_stat", i), {62'd0, busy[i], done[i]}, 64'd0);
      check_val($sformatf("d%0d_midrst_add", i), {add_a[i], add_b[i]}, 64'd0);
      prev_res[i] = 64'd0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h0001_0003, 32'hFFFF_0002, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
